// File: rtl/multi_channel_pausable_clock_pkg.sv
// Shared types and defaults for the multi-channel pausable clock generator.
package multi_channel_pausable_clock_pkg;

  localparam int unsigned DEFAULT_NUM_CHANNELS       = 4;
  localparam int unsigned DEFAULT_RATE_COUNTER_WIDTH = 16;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } pause_state_e;

  typedef struct packed {
    logic [DEFAULT_RATE_COUNTER_WIDTH-1:0] half_rate;
    logic                                  starting_polarity;
    logic                                  pause_polarity;
  } channel_cfg_s;

  typedef struct packed {
    logic                                  pause_active;
    logic [DEFAULT_RATE_COUNTER_WIDTH-1:0] pause_duration;
    logic                                  locked;
  } channel_status_s;

endpackage

// File: rtl/multi_channel_pausable_clock_channel.sv
// One clock channel: half-period divider, RUN/PAUSED gating FSM and
// registered clocks, edge events and pause-duration counter.
module pausable_clock_channel
  import multi_channel_pausable_clock_pkg::*;
#(
  parameter int unsigned W = DEFAULT_RATE_COUNTER_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         generation_en_i,
  input  logic         init_i,
  input  logic         starting_polarity_i,
  input  logic [W-1:0] half_rate_i,
  input  logic         locked_i,
  input  logic         pause_en_i,
  input  logic         pause_polarity_i,
  output logic         unpaused_clk_o,
  output logic         unpaused_rise_o,
  output logic         unpaused_fall_o,
  output logic         paused_clk_o,
  output logic         paused_rise_o,
  output logic         paused_fall_o,
  output logic         pause_active_o,
  output logic [W-1:0] pause_duration_o,
  output logic         locked_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  pause_state_e state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] dur_q, dur_d;
  logic         uclk_q, uclk_d;
  logic         pclk_q, pclk_d;
  logic         pol_q, pol_d;
  logic         urise_q, urise_d, ufall_q, ufall_d;
  logic         prise_q, prise_d, pfall_q, pfall_d;
  logic         locked_q;
  logic         load_s, run_s, toggle_s, uclk_nxt_s;

  // Init wins over generation; a zero half-rate parks the divider.
  assign load_s     = clk_en && init_i;
  assign run_s      = clk_en && !init_i && generation_en_i && (half_rate_i != '0);
  assign toggle_s   = run_s && (cnt_q >= (half_rate_i - ONE));
  assign uclk_nxt_s = ~uclk_q;

  // Divider count next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (load_s) begin
      cnt_d = '0;
    end else if (clk_en && generation_en_i && (half_rate_i == '0)) begin
      cnt_d = '0;
    end else if (toggle_s) begin
      cnt_d = '0;
    end else if (run_s) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pause FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pause FSM next-state: transitions happen only on toggle cycles.
  always_comb begin
    state_d = state_q;
    if (load_s) begin
      state_d = RUN;
    end else if (toggle_s) begin
      case (state_q)
        RUN: begin
          if (pause_en_i) state_d = PAUSED;
          else            state_d = RUN;
        end
        PAUSED: begin
          if (!pause_en_i && (uclk_nxt_s != pol_q)) state_d = RUN;
          else                                      state_d = PAUSED;
        end
        default: state_d = RUN;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM outputs: clock values, latched polarity and suppressed-toggle count.
  always_comb begin
    uclk_d = uclk_q;
    pclk_d = pclk_q;
    pol_d  = pol_q;
    dur_d  = dur_q;
    if (load_s) begin
      uclk_d = starting_polarity_i;
      pclk_d = starting_polarity_i;
    end else if (toggle_s) begin
      uclk_d = uclk_nxt_s;
      case (state_q)
        RUN: begin
          if (pause_en_i) begin
            pol_d = pause_polarity_i;
            // Already parked at the pause level: this toggle is the first suppressed one.
            if (pclk_q == pause_polarity_i) begin
              pclk_d = pclk_q;
              dur_d  = ONE;
            end else begin
              pclk_d = uclk_nxt_s;
              dur_d  = '0;
            end
          end else begin
            pclk_d = uclk_nxt_s;
          end
        end
        PAUSED: begin
          if (state_d == RUN) begin
            pclk_d = uclk_nxt_s;
          end else if (uclk_nxt_s != pol_q) begin
            pclk_d = pol_q;
            dur_d  = (dur_q == '1) ? dur_q : (dur_q + ONE);
          end else begin
            pclk_d = pol_q;
          end
        end
        default: pclk_d = uclk_nxt_s;
      endcase
    end else begin
      uclk_d = uclk_q;
    end
  end

  // Edge events are qualified by toggle_s so init reloads never emit them.
  always_comb begin
    urise_d = toggle_s && uclk_nxt_s;
    ufall_d = toggle_s && !uclk_nxt_s;
    prise_d = toggle_s && pclk_d && !pclk_q;
    pfall_d = toggle_s && !pclk_d && pclk_q;
  end

  // Datapath and event registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dur_q    <= '0;
      uclk_q   <= 1'b0;
      pclk_q   <= 1'b0;
      pol_q    <= 1'b0;
      urise_q  <= 1'b0;
      ufall_q  <= 1'b0;
      prise_q  <= 1'b0;
      pfall_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dur_q    <= dur_d;
      uclk_q   <= uclk_d;
      pclk_q   <= pclk_d;
      pol_q    <= pol_d;
      urise_q  <= urise_d;
      ufall_q  <= ufall_d;
      prise_q  <= prise_d;
      pfall_q  <= pfall_d;
      locked_q <= locked_i;
    end
  end

  assign unpaused_clk_o   = uclk_q;
  assign unpaused_rise_o  = urise_q;
  assign unpaused_fall_o  = ufall_q;
  assign paused_clk_o     = pclk_q;
  assign paused_rise_o    = prise_q;
  assign paused_fall_o    = pfall_q;
  assign pause_active_o   = (state_q == PAUSED);
  assign pause_duration_o = dur_q;
  assign locked_o         = locked_q;

endmodule

// File: rtl/multi_channel_pausable_clock.sv
// NUM_CHANNELS independent software-rate clocks derived from clk; this level
// only slices the flattened buses and replicates the channel.
module multi_channel_pausable_clock
  import multi_channel_pausable_clock_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS       = DEFAULT_NUM_CHANNELS,
  parameter int unsigned RATE_COUNTER_WIDTH = DEFAULT_RATE_COUNTER_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clk_en,
  input  logic [NUM_CHANNELS-1:0]                    generation_en_i,
  input  logic [NUM_CHANNELS-1:0]                    init_i,
  input  logic [NUM_CHANNELS-1:0]                    starting_polarity_i,
  input  logic [NUM_CHANNELS*RATE_COUNTER_WIDTH-1:0] half_rate_i,
  input  logic [NUM_CHANNELS-1:0]                    locked_i,
  input  logic [NUM_CHANNELS-1:0]                    pause_en_i,
  input  logic [NUM_CHANNELS-1:0]                    pause_polarity_i,
  output logic [NUM_CHANNELS-1:0]                    unpaused_clk_o,
  output logic [NUM_CHANNELS-1:0]                    unpaused_rise_o,
  output logic [NUM_CHANNELS-1:0]                    unpaused_fall_o,
  output logic [NUM_CHANNELS-1:0]                    paused_clk_o,
  output logic [NUM_CHANNELS-1:0]                    paused_rise_o,
  output logic [NUM_CHANNELS-1:0]                    paused_fall_o,
  output logic [NUM_CHANNELS-1:0]                    pause_active_o,
  output logic [NUM_CHANNELS*RATE_COUNTER_WIDTH-1:0] pause_duration_o,
  output logic [NUM_CHANNELS-1:0]                    locked_o
);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    pausable_clock_channel #(
      .W(RATE_COUNTER_WIDTH)
    ) u_ch (
      .clk                 (clk),
      .rst_n               (rst_n),
      .clk_en              (clk_en),
      .generation_en_i     (generation_en_i[g]),
      .init_i              (init_i[g]),
      .starting_polarity_i (starting_polarity_i[g]),
      .half_rate_i         (half_rate_i[g*RATE_COUNTER_WIDTH +: RATE_COUNTER_WIDTH]),
      .locked_i            (locked_i[g]),
      .pause_en_i          (pause_en_i[g]),
      .pause_polarity_i    (pause_polarity_i[g]),
      .unpaused_clk_o      (unpaused_clk_o[g]),
      .unpaused_rise_o     (unpaused_rise_o[g]),
      .unpaused_fall_o     (unpaused_fall_o[g]),
      .paused_clk_o        (paused_clk_o[g]),
      .paused_rise_o       (paused_rise_o[g]),
      .paused_fall_o       (paused_fall_o[g]),
      .pause_active_o      (pause_active_o[g]),
      .pause_duration_o    (pause_duration_o[g*RATE_COUNTER_WIDTH +: RATE_COUNTER_WIDTH]),
      .locked_o            (locked_o[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_pausable_clock.sv
// Scoreboard bench: a behavioural channel model pushes expected outputs per
// cycle, popped and compared after each clock edge, plus directed checkpoints.
module tb_multi_channel_pausable_clock;

  localparam int NC = 4;
  localparam int W  = 16;

  typedef struct packed {
    logic [NC-1:0]   uclk, urise, ufall, pclk, prise, pfall, pact, lock;
    logic [NC*W-1:0] dur;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clk_en = 1'b1;
  logic [NC-1:0]   gen = '0, init = '0, sp = '0, locked = '0, pen = '0, ppol = '0;
  logic [NC*W-1:0] hr = '0;
  logic [NC-1:0]   uclk_o, urise_o, ufall_o, pclk_o, prise_o, pfall_o, pact_o, lock_o;
  logic [NC*W-1:0] dur_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t sb_q[$];

  // Reference model state.
  int m_cnt[NC];
  int m_dur[NC];
  bit m_u[NC], m_p[NC], m_pa[NC], m_pol[NC], m_lk[NC];
  bit m_ur[NC], m_uf[NC], m_pr[NC], m_pf[NC];

  multi_channel_pausable_clock #(.NUM_CHANNELS(NC), .RATE_COUNTER_WIDTH(W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clk_en              (clk_en),
    .generation_en_i     (gen),
    .init_i              (init),
    .starting_polarity_i (sp),
    .half_rate_i         (hr),
    .locked_i            (locked),
    .pause_en_i          (pen),
    .pause_polarity_i    (ppol),
    .unpaused_clk_o      (uclk_o),
    .unpaused_rise_o     (urise_o),
    .unpaused_fall_o     (ufall_o),
    .paused_clk_o        (pclk_o),
    .paused_rise_o       (prise_o),
    .paused_fall_o       (pfall_o),
    .pause_active_o      (pact_o),
    .pause_duration_o    (dur_o),
    .locked_o            (lock_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0; m_dur[c] = 0; m_u[c] = 0; m_p[c] = 0; m_pa[c] = 0;
      m_pol[c] = 0; m_lk[c] = 0; m_ur[c] = 0; m_uf[c] = 0; m_pr[c] = 0; m_pf[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      int h;
      bit nu, old_p;
      h = int'(hr[c*W +: W]);
      m_ur[c] = 0; m_uf[c] = 0; m_pr[c] = 0; m_pf[c] = 0;
      if (clk_en) begin
        if (init[c]) begin
          m_u[c] = sp[c]; m_p[c] = sp[c]; m_cnt[c] = 0; m_pa[c] = 0;
        end else if (gen[c] && h == 0) begin
          m_cnt[c] = 0;
        end else if (gen[c]) begin
          if (m_cnt[c] + 1 >= h) begin
            m_cnt[c] = 0;
            nu = !m_u[c];
            m_u[c] = nu; m_ur[c] = nu; m_uf[c] = !nu;
            old_p = m_p[c];
            if (!m_pa[c]) begin
              if (pen[c]) begin
                m_pa[c] = 1; m_pol[c] = ppol[c];
                m_dur[c] = (old_p == ppol[c]) ? 1 : 0;
                m_p[c] = ppol[c];
              end else begin
                m_p[c] = nu;
              end
            end else if (nu != m_pol[c]) begin
              if (!pen[c]) begin
                m_pa[c] = 0; m_p[c] = nu;
              end else if (m_dur[c] < 65535) begin
                m_dur[c]++;
              end
            end
            m_pr[c] = !old_p && m_p[c];
            m_pf[c] = old_p && !m_p[c];
          end else begin
            m_cnt[c]++;
          end
        end
      end
      m_lk[c] = locked[c];
    end
  endtask

  task automatic step();
    exp_t e, x;
    model_step();
    for (int c = 0; c < NC; c++) begin
      e.uclk[c] = m_u[c]; e.urise[c] = m_ur[c]; e.ufall[c] = m_uf[c];
      e.pclk[c] = m_p[c]; e.prise[c] = m_pr[c]; e.pfall[c] = m_pf[c];
      e.pact[c] = m_pa[c]; e.lock[c] = m_lk[c];
      e.dur[c*W +: W] = m_dur[c][W-1:0];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    x = sb_q.pop_front();
    chk("uclk", 64'(uclk_o), 64'(x.uclk));
    chk("urise", 64'(urise_o), 64'(x.urise));
    chk("ufall", 64'(ufall_o), 64'(x.ufall));
    chk("pclk", 64'(pclk_o), 64'(x.pclk));
    chk("prise", 64'(prise_o), 64'(x.prise));
    chk("pfall", 64'(pfall_o), 64'(x.pfall));
    chk("pact", 64'(pact_o), 64'(x.pact));
    chk("dur", dur_o, x.dur);
    chk("lock", 64'(lock_o), 64'(x.lock));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clk"}, 64'({uclk_o, pclk_o}), 64'd0);
    chk({tag, "_ev"}, 64'({urise_o, ufall_o, prise_o, pfall_o}), 64'd0);
    chk({tag, "_st"}, 64'({pact_o, lock_o}), 64'd0);
    chk({tag, "_dur"}, dur_o, 64'd0);
  endtask

  task automatic init_ch(input int c, input bit pol, input int rate);
    hr[c*W +: W] = rate[W-1:0];
    sp[c] = pol; init[c] = 1'b1; gen[c] = 1'b1;
    step();
    init[c] = 1'b0;
  endtask

  initial begin
    int first_rise;
    model_reset();
    locked = 4'b1010;
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Basic divide-by-3 timing on ch0.
    init_ch(0, 1'b0, 3);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("s1_rise", 64'(urise_o[0]), 64'(k == 3 || k == 9 || k == 15));
      chk("s1_fall", 64'(ufall_o[0]), 64'(k == 6 || k == 12));
    end

    // Pause entry with let-through, duration counting, exit in phase.
    init_ch(0, 1'b1, 4);
    pen[0] = 1'b1; ppol[0] = 1'b0;
    repeat (4) step();
    chk("s2_entry_pclk", 64'(pclk_o[0]), 64'd0);
    chk("s2_entry_pact", 64'(pact_o[0]), 64'd1);
    chk("s2_entry_dur", dur_o[W-1:0], 64'd0);
    ppol[0] = 1'b1;
    repeat (20) step();
    chk("s2_dur3", dur_o[W-1:0], 64'd3);
    chk("s2_hold_pclk", 64'(pclk_o[0]), 64'd0);
    pen[0] = 1'b0;
    repeat (8) step();
    chk("s2_exit_prise", 64'(prise_o[0]), 64'd1);
    chk("s2_exit_pact", 64'(pact_o[0]), 64'd0);
    chk("s2_exit_phase", 64'(pclk_o[0]), 64'(uclk_o[0]));

    // Pause requested while already at polarity: immediate suppression.
    pen[0] = 1'b1; ppol[0] = 1'b1;
    repeat (4) step();
    chk("s3_supp_dur", dur_o[W-1:0], 64'd1);
    chk("s3_supp_pclk", 64'(pclk_o[0]), 64'd1);
    chk("s3_supp_uclk", 64'(uclk_o[0]), 64'd0);
    pen[0] = 1'b0;
    repeat (8) step();

    // Rate decrease mid half-period.
    init_ch(0, 1'b0, 10);
    repeat (7) step();
    hr[0 +: W] = 16'd2;
    step();
    chk("s4_fast_rise", 64'(urise_o[0]), 64'd1);
    step(); step();
    chk("s4_fast_fall", 64'(ufall_o[0]), 64'd1);

    // clk_en low for 5 cycles stretches the half period by 5.
    init_ch(0, 1'b0, 4);
    first_rise = 0;
    for (int k = 1; k <= 12; k++) begin
      clk_en = !(k >= 3 && k <= 7);
      step();
      if (k >= 3 && k <= 7) chk("s5_quiet", 64'({urise_o, ufall_o}), 64'd0);
      if (urise_o[0] && first_rise == 0) first_rise = k;
    end
    clk_en = 1'b1;
    chk("s5_stretch", 64'(first_rise), 64'd9);

    // Four independent channels, init ch2 mid-pause.
    hr = {16'd0, 16'd3, 16'd2, 16'd1};
    sp = 4'b0101; init = 4'b1111; gen = 4'b1111;
    step();
    init = '0;
    pen[2] = 1'b1; ppol[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      locked = 4'($urandom);
      step();
    end
    chk("s6_ch2_paused", 64'(pact_o[2]), 64'd1);
    chk("s6_ch3_static", 64'(uclk_o[3]), 64'd0);
    sp[2] = 1'b1; init[2] = 1'b1;
    step();
    init[2] = 1'b0; pen[2] = 1'b0;
    chk("s6_init_pact", 64'(pact_o[2]), 64'd0);
    chk("s6_init_pclk", 64'(pclk_o[2]), 64'd1);
    repeat (10) step();

    // Randomised traffic across all channels.
    for (int k = 0; k < 400; k++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      pen    = 4'($urandom);
      ppol   = 4'($urandom);
      locked = 4'($urandom);
      gen    = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b1111;
      init   = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'b0000;
      sp     = 4'($urandom);
      if ($urandom_range(0, 49) == 0) hr[$urandom_range(0, 3)*W +: W] = 16'($urandom_range(0, 4));
      step();
    end
    init = '0; clk_en = 1'b1;

    // Asynchronous reset asserted between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("async_rst_hold");
    rst_n = 1'b1;
    model_reset();
    gen = '0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
